// File: rtl/tcm_boot_pkg.sv
// Shared types and constants for the TCM boot loader.
// Contents: FSM state enum, word/lane geometry, checksum width.
package tcm_boot_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned LANE_W         = 2;
    localparam int unsigned WORD_W         = 8 * BYTES_PER_WORD;
    localparam int unsigned CSUM_W         = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        CAPTURE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4,
        ERROR   = 3'd5
    } state_e;

endpackage

// File: rtl/tcm_boot_word_packer.sv
// Assembles ROM bytes into little-endian 32-bit words.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   capture     - store data into the current lane and advance the lane
//   data        - ROM byte
//   word        - assembled word buffer (registered)
//   lane        - lane the next captured byte goes to (registered)
//   last_lane_c - current lane is the top byte of the word
module tcm_boot_word_packer
    import tcm_boot_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic [7:0]        data,
    output logic [WORD_W-1:0] word,
    output logic [LANE_W-1:0] lane,
    output logic              last_lane_c
);

    // Byte-lane buffer and lane counter
    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            lane <= '0;
        end else if (capture) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (lane == LANE_W'(i)) begin
                    word[8*i +: 8] <= data;
                end
            end
            lane <= lane + LANE_W'(1);
        end
    end

    assign last_lane_c = (lane == LANE_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/tcm_boot_loader.sv
// Copies a boot image byte-by-byte from ROM into TCM as 32-bit words,
// then releases the CPU core from reset.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - load trigger (only when AUTO_START == 0)
//   rom_rd, rom_addr    - ROM read strobe and byte address
//   rom_data            - ROM data, valid one cycle after rom_rd
//   tcm_req, tcm_addr,
//   tcm_wdata, tcm_ack  - TCM word write handshake
//   core_rst_n          - CPU core reset, released only after a good load
//   busy, done, error   - load status
// Optional build macro BOOT_CHECKSUM_EN: the last image word is a mod-2^32
// checksum of all preceding words and is verified before releasing the core.
module tcm_boot_loader
    import tcm_boot_pkg::*;
#(
    parameter int unsigned IMAGE_BYTES = 65536,
    parameter int unsigned ROM_AW      = 17,
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter int unsigned AUTO_START  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rom_rd,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic              tcm_req,
    output logic [31:0]       tcm_addr,
    output logic [31:0]       tcm_wdata,
    input  logic              tcm_ack,
    output logic              core_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned K_W      = $clog2(IMAGE_BYTES + 1);
    localparam int unsigned TMO_W    = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned LAST_TMO = ACK_TIMEOUT - 1;

    state_e              state;
    state_e              state_next;
    logic [K_W-1:0]      k;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [31:0]         word_addr;
    logic [WORD_W-1:0]   word;
    logic [LANE_W-1:0]   lane;
    logic                last_lane_c;
    logic                capture_c;
    logic                acked_c;
    logic                last_word_c;
    logic                sum_ok_c;
    logic                rom_rd_next;
    logic                tcm_req_next;
    logic                busy_next;
    logic                done_next;
    logic                error_next;

    tcm_boot_word_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture_c),
        .data        (rom_data),
        .word        (word),
        .lane        (lane),
        .last_lane_c (last_lane_c)
    );

    // Only acks seen while a write is outstanding count
    assign acked_c     = (state == WRITE) && tcm_ack;
    assign last_word_c = (k == K_W'(IMAGE_BYTES));

`ifdef BOOT_CHECKSUM_EN
    logic [CSUM_W-1:0] csum;

    // Running sum of every acked word except the final checksum word
    always_ff @(posedge clk) begin
        if (rst) begin
            csum <= '0;
        end else if (acked_c && !last_word_c) begin
            csum <= csum + CSUM_W'(word);
        end
    end

    assign sum_ok_c = (csum == CSUM_W'(word));
`else
    assign sum_ok_c = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and next-cycle output decode
    always_comb begin
        state_next   = state;
        capture_c    = 1'b0;
        rom_rd_next  = 1'b0;
        tcm_req_next = 1'b0;
        busy_next    = 1'b0;
        done_next    = 1'b0;
        error_next   = 1'b0;

        case (state)
            IDLE: begin
                if ((AUTO_START != 0) || start) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                capture_c  = 1'b1;
                state_next = last_lane_c ? WRITE : FETCH;
            end
            WRITE: begin
                if (tcm_ack) begin
                    if (!last_word_c) begin
                        state_next = FETCH;
                    end else begin
                        state_next = sum_ok_c ? DONE : ERROR;
                    end
                end else if (tmo_cnt == TMO_W'(LAST_TMO)) begin
                    state_next = ERROR;
                end
            end
            DONE, ERROR: begin
                state_next = state;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        rom_rd_next  = (state_next == FETCH);
        tcm_req_next = (state_next == WRITE);
        busy_next    = rom_rd_next || tcm_req_next || (state_next == CAPTURE);
        done_next    = (state_next == DONE);
        error_next   = (state_next == ERROR);
    end

    // Byte index, ack timeout counter, TCM word address and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            k          <= '0;
            tmo_cnt    <= '0;
            word_addr  <= '0;
            rom_rd     <= 1'b0;
            tcm_req    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            core_rst_n <= 1'b0;
        end else begin
            if (capture_c) begin
                k <= k + K_W'(1);
            end
            if ((state_next == WRITE) && (state != WRITE)) begin
                tmo_cnt <= '0;
            end else if (state == WRITE) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (acked_c) begin
                word_addr <= word_addr + 32'(BYTES_PER_WORD);
            end
            rom_rd     <= rom_rd_next;
            tcm_req    <= tcm_req_next;
            busy       <= busy_next;
            done       <= done_next;
            error      <= error_next;
            core_rst_n <= done_next;
        end
    end

    // k, the word address and the packed word are all flops; no capture
    // happens during WRITE, so address and data hold for the whole request
    assign rom_addr  = ROM_AW'(k);
    assign tcm_addr  = word_addr;
    assign tcm_wdata = word;

endmodule
